// File: rtl/vga_scan_engine.sv
// -----------------------------------------------------------------------------
// vga_scan_engine
//
// Parametrised VGA scan-out engine. Free-running horizontal/vertical counters
// generate sync and display-enable timing, compute a framebuffer byte address
// for every clock, pick the pixel field out of the returned byte (1/2/4/8 bpp,
// MSB-first), look it up in a writable 256x12 palette and drive RGB.
//
// Pipeline (all outputs reflect the counter state three clocks earlier):
//   c0  hcnt/vcnt counters
//   c1  ADDR register
//   c2  DATA returns from the framebuffer, palette index formed
//   c3  palette read register == RGB output register
//
// Ports:
//   CLK       pixel clock
//   RST       synchronous active-high reset
//   DATA      framebuffer byte, valid one clock after ADDR
//   ADDR      framebuffer byte address (registered)
//   RW        tied to 1 (read-only framebuffer access)
//   MODE      0=1bpp 1=2bpp 2=4bpp 3=8bpp, latched at frame start
//   FB_BASE   frame start address, latched at frame start
//   PAL_WE    palette write strobe
//   PAL_IDX   palette write index
//   PAL_DATA  palette entry R[11:8] G[7:4] B[3:0]
//   INT_ACK   releases a pending vblank interrupt
//   INT       active-low vblank interrupt
//   DE        display enable, aligned with RGB
//   HSYNC     active-low horizontal sync
//   VSYNC     active-low vertical sync
//   RGB       pixel colour, zero outside the active region
// -----------------------------------------------------------------------------
module vga_scan_engine #(
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 400,
    parameter int V_FP         = 12,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 35,
    parameter int H_SCALE_LOG2 = 1,
    parameter int V_SCALE_LOG2 = 1,
    parameter int ADDR_W       = 15
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [7:0]        DATA,
    output logic [ADDR_W-1:0] ADDR,
    output logic              RW,
    input  logic [1:0]        MODE,
    input  logic [ADDR_W-1:0] FB_BASE,
    input  logic              PAL_WE,
    input  logic [7:0]        PAL_IDX,
    input  logic [11:0]       PAL_DATA,
    input  logic              INT_ACK,
    output logic              INT,
    output logic              DE,
    output logic              HSYNC,
    output logic              VSYNC,
    output logic [11:0]       RGB
);

    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(HT);
    localparam int VW = $clog2(VT);

    localparam logic [HW-1:0] H_LAST   = HW'(HT - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(VT - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_ACT_M1 = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

    // Control bundle carried down the pipeline: {de, hsync_n, vsync_n}
    localparam logic [2:0] CTL_IDLE = 3'b011;

    // ------------------------------------------------------------------ state
    logic [HW-1:0]     hcnt_q, hcnt_d;
    logic [VW-1:0]     vcnt_q, vcnt_d;
    logic [1:0]        shadow_mode_q, shadow_mode_d;
    logic [ADDR_W-1:0] shadow_base_q, shadow_base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              int_q, int_d;
    logic [11:0]       rgb_q, rgb_d;

    logic [2:0]        ctl_q [3];
    logic [2:0]        ctl_d [3];
    // Pixel-select bundle {mode, px[2:0]} for stages c1 and c2
    logic [4:0]        sel_q [2];
    logic [4:0]        sel_d [2];

    logic [11:0]       pal_mem [256];

    // ------------------------------------------------------------ c0 logic
    logic              h_wrap;
    logic              frame_start;
    logic [1:0]        mode_eff;
    logic [ADDR_W-1:0] base_eff;
    logic [HW-1:0]     px;
    logic [VW-1:0]     ln;
    logic [31:0]       bpl;
    logic [2:0]        ctl_c0;
    logic [4:0]        sel_c0;

    always_comb begin
        h_wrap = (hcnt_q == H_LAST);
        hcnt_d = h_wrap ? '0 : hcnt_q + 1'b1;
        vcnt_d = vcnt_q;
        if (h_wrap) begin
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
        end

        // The first pixel of a frame already uses the freshly sampled
        // MODE/FB_BASE; the shadow copy then holds them for the rest of it.
        frame_start   = (hcnt_q == '0) && (vcnt_q == '0);
        mode_eff      = frame_start ? MODE    : shadow_mode_q;
        base_eff      = frame_start ? FB_BASE : shadow_base_q;
        shadow_mode_d = mode_eff;
        shadow_base_d = base_eff;

        px  = hcnt_q >> H_SCALE_LOG2;
        ln  = vcnt_q >> V_SCALE_LOG2;
        // bytes per image line = image width * bpp / 8, bpp = 1 << mode
        bpl = (32'(H_ACTIVE >> H_SCALE_LOG2) << mode_eff) >> 3;
        // Sum is formed at 32 bits and truncated so the address wraps.
        addr_d = ADDR_W'(32'(base_eff) + 32'(ln) * bpl + ((32'(px) << mode_eff) >> 3));

        ctl_c0 = {(hcnt_q < H_ACT) && (vcnt_q < V_ACT),
                  !((hcnt_q >= HS_BEG) && (hcnt_q < HS_END)),
                  !((vcnt_q >= VS_BEG) && (vcnt_q < VS_END))};
        sel_c0 = {mode_eff, px[2:0]};

        // Interrupt set (vcnt entering V_ACTIVE) has priority over ack.
        if (h_wrap && (vcnt_q == V_ACT_M1)) begin
            int_d = 1'b0;
        end else if (INT_ACK) begin
            int_d = 1'b1;
        end else begin
            int_d = int_q;
        end
    end

    // ------------------------------------------------- pipeline delay chains
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_ctl
            if (gi == 0) begin : g_first
                assign ctl_d[gi] = ctl_c0;
            end else begin : g_next
                assign ctl_d[gi] = ctl_q[gi-1];
            end
        end
        for (gi = 0; gi < 2; gi++) begin : g_sel
            if (gi == 0) begin : g_first
                assign sel_d[gi] = sel_c0;
            end else begin : g_next
                assign sel_d[gi] = sel_q[gi-1];
            end
        end
    endgenerate

    // ------------------------------------------------------------ c2 logic
    logic [1:0] sel_mode;
    logic [2:0] sel_px;
    logic [1:0] field;
    logic [7:0] pix_idx;

    always_comb begin
        sel_mode = sel_q[1][4:3];
        sel_px   = sel_q[1][2:0];
        field    = 2'd3 - sel_px[1:0];
        pix_idx  = 8'h00;
        case (sel_mode)
            2'd0:    pix_idx = {7'b0, DATA[3'd7 - sel_px]};
            2'd1:    pix_idx = (DATA >> {field, 1'b0}) & 8'h03;
            2'd2:    pix_idx = sel_px[0] ? {4'b0, DATA[3:0]} : {4'b0, DATA[7:4]};
            default: pix_idx = DATA;
        endcase
        // Gated with the c2 enable so blanking always drives black.
        rgb_d = ctl_q[1][2] ? pal_mem[pix_idx] : 12'h000;
    end

    // ------------------------------------------------------------- registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            shadow_mode_q <= 2'd2;
            shadow_base_q <= '0;
            addr_q        <= '0;
            int_q         <= 1'b1;
            rgb_q         <= 12'h000;
            for (int i = 0; i < 3; i++) ctl_q[i] <= CTL_IDLE;
            for (int i = 0; i < 2; i++) sel_q[i] <= '0;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            shadow_mode_q <= shadow_mode_d;
            shadow_base_q <= shadow_base_d;
            addr_q        <= addr_d;
            int_q         <= int_d;
            rgb_q         <= rgb_d;
            for (int i = 0; i < 3; i++) ctl_q[i] <= ctl_d[i];
            for (int i = 0; i < 2; i++) sel_q[i] <= sel_d[i];
        end
    end

    // Palette storage is deliberately outside reset. A same-cycle write and
    // read of one index returns the old entry since the read above sees the
    // array before this edge's update lands.
    always_ff @(posedge CLK) begin
        if (PAL_WE) begin
            pal_mem[PAL_IDX] <= PAL_DATA;
        end
    end

    // --------------------------------------------------------------- outputs
    assign ADDR  = addr_q;
    assign RW    = 1'b1;
    assign INT   = int_q;
    assign DE    = ctl_q[2][2];
    assign HSYNC = ctl_q[2][1];
    assign VSYNC = ctl_q[2][0];
    assign RGB   = rgb_q;

endmodule

// File: doc/vga_scan_engine.md
Name: vga_scan_engine

Overview:
Parametrised VGA scan-out engine generalising the fixed 4bpp 640x400 controller. It reads a byte-wide framebuffer over a synchronous-read bus and provides programmable timing, pixel scaling, and selectable 1/2/4/8 bpp modes. It adds a writable 256x12 palette, per-frame base-address latching for page flipping, and a vblank interrupt with an acknowledge handshake. It sits between video RAM and the DAC/pins, in the same place as the existing controller.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync width
H_BP, 48, horizontal back porch
V_ACTIVE, 400, visible lines
V_FP, 12, vertical front porch (lines)
V_SYNC, 2, vsync width
V_BP, 35, vertical back porch
H_SCALE_LOG2, 1, each image pixel spans 2^n clocks
V_SCALE_LOG2, 1, each image line spans 2^n scanlines
ADDR_W, 15, framebuffer address width

Ports:
CLK  in  1  pixel clock
RST  in  1  synchronous active-high reset
DATA  in  8  framebuffer byte, valid one clock after ADDR
ADDR  out  ADDR_W  framebuffer byte address (registered)
RW  out  1  constant 1 (read-only)
MODE  in  2  0=1bpp, 1=2bpp, 2=4bpp, 3=8bpp
FB_BASE  in  ADDR_W  frame start address
PAL_WE  in  1  palette write strobe
PAL_IDX  in  8  palette write index
PAL_DATA  in  12  palette entry, R[11:8] G[7:4] B[3:0]
INT_ACK  in  1  clears pending interrupt
INT  out  1  active-low vblank interrupt
DE  out  1  display enable, aligned with RGB
HSYNC  out  1  active-low
VSYNC  out  1  active-low
RGB  out  12  pixel colour

Behaviour:
- Counters: hcnt 0..HT-1 with HT=H_ACTIVE+H_FP+H_SYNC+H_BP; vcnt 0..VT-1 with VT defined likewise. vcnt increments on hcnt wrap. Both wrap to 0 on the same clock at the end of the frame.
- Sync: hsync active for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). vsync is defined the same way on vcnt. Active region: hcnt<H_ACTIVE and vcnt<V_ACTIVE.
- Frame latch: at hcnt=0, vcnt=0, MODE and FB_BASE are captured into shadow registers. Changes mid-frame take effect next frame.
- Address calculation:
  - px = hcnt>>H_SCALE_LOG2; ln = vcnt>>V_SCALE_LOG2.
  - BPL = (H_ACTIVE>>H_SCALE_LOG2)*bpp/8.
  - ADDR = base + ln*BPL + (px*bpp>>3), truncated mod 2^ADDR_W (wraps).
  - Scanlines within the same ln reread identical addresses.
- Pixel select: bit field within DATA, MSB-first. 1bpp: bit 7-(px%8). 2bpp: field 3-(px%4). 4bpp: high nibble for even px. 8bpp: whole byte. The index is zero-extended to 8 bits and looked up in the palette.
- Pipeline:
  - Counter stage (c0), ADDR register (c1), DATA + palette read (c2), RGB register (c3).
  - HSYNC, VSYNC and DE are delayed to match, so all four outputs reflect the counter state 3 clocks earlier.
  - RGB=0 whenever the delayed DE=0.
- Palette:
  - 256x12 synchronous RAM; PAL_WE writes PAL_DATA at PAL_IDX.
  - A write and a read of the same index in the same cycle returns the old value; the new value is visible the next cycle.
  - Contents are not affected by RST.
- Interrupt:
  - INT goes 0 on the clock where vcnt becomes V_ACTIVE (hcnt=0).
  - INT stays 0 until INT_ACK=1, which releases it to 1 next clock.
  - Set and ack in the same cycle: set wins (INT=0).
- Reset (RST=1 at a CLK edge), regardless of operation in progress:
  - hcnt=vcnt=0, ADDR=0, RGB=0, DE=0, HSYNC=1, VSYNC=1, INT=1.
  - Pipeline delay registers cleared.
  - Shadow MODE=2, shadow base=0.
- RW is tied to 1.

Test Plan:
- Reset: hold RST 3 clocks mid-line → ADDR=0, RGB=0, HSYNC=VSYNC=INT=1, DE=0; first DE=1 appears 3 clocks after release.
- Sync timing (defaults): HSYNC=0 for exactly 96 clocks starting 3 clocks after hcnt=656; line period 800; VSYNC=0 for 2 lines starting at line 412; frame 449 lines.
- 4bpp default, FB_BASE=0x100:
  - Line 0 ADDR sequence is 0x100 for clocks 0-3, then 0x101, ...; last is 0x19F.
  - Line 1 repeats 0x100..0x19F; line 2 starts at 0x1A0.
  - With palette[0xA]=0xEB1 and DATA=0xA0 → RGB=0xEB1 for 2 clocks, then palette[0].
- 8bpp and 1bpp:
  - MODE=3 with DATA=0xFF and palette[0xFF]=0xFFF → RGB=0xFFF; BPL=320.
  - MODE=0 with DATA=0x80 → first pixel uses palette[1], next 7 use palette[0]; BPL=40.
- Mid-frame MODE/FB_BASE change at line 100 → rest of frame unchanged; next frame uses the new values.
- Interrupt: INT falls at vcnt=400. INT_ACK pulse at line 405 → INT=1 next clock. INT_ACK held across the next line-400 edge → INT=0 (set wins).
